// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, responses
// buffered in a small FIFO toward decode; redirect flushes and drops in-flight work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_plus4,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   pc;
  entry_t        q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          push, pop;

  assign pc_plus4  = pc + 32'd4;
  assign out_valid = (count != '0);
  assign out_pc    = q[head].pc;
  assign out_instr = q[head].instr;

  // A response is kept only if the same cycle carries no redirect.
  assign push = (state == REQ) && imem_ack && !redirect;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= '0;
      imem_req  <= 1'b0;
    end else begin
      if (redirect || push) pc <= next_pc;
      unique case (state)
        IDLE: begin
          // The slot is reserved here, so the later push cannot overflow.
          if (!redirect && count < QFULL) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          // The ack retires the stale request even if another redirect lands with it.
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q[tail] <= '{pc: imem_addr, instr: imem_data};
        tail    <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit; two instances (RESET_PC 0 and
// 0xFFFF_FFFC) share control stimulus, so one timing model covers both.
module tb_fetch_unit;
  localparam int          QD  = 2;
  localparam logic [31:0] RP0 = 32'h0000_0000;
  localparam logic [31:0] RP1 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, redirect = 1'b0, imem_ack = 1'b0, out_ready = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc4_a, pc4_b, nxt_a, nxt_b, addr_a, addr_b, data_a, data_b;
  logic [31:0] opc_a, opc_b, oin_a, oin_b;
  logic        req_a, req_b, ov_a, ov_b;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: request outstanding / response to be dropped, plus an
  // ordered list of fetched addresses per instance.
  typedef struct {
    logic [31:0] a0;
    logic [31:0] a1;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] m_pc[2], m_addr[2];
  bit          m_busy = 0, m_disc = 0, m_rst_seen = 0, mon_popped = 0, run = 0;
  int          total = 0, bad = 0;
  int          p_rst = 100, p_redir = 0, p_ack = 100, p_ready = 100;

  assign nxt_a  = redirect ? tgt : pc4_a;
  assign nxt_b  = redirect ? tgt : pc4_b;
  assign data_a = memf(m_addr[0]);
  assign data_b = memf(m_addr[1]);

  fetch_unit #(.RESET_PC(RP0), .QDEPTH(QD)) dut_a (
    .clk(clk), .rst(rst), .pc_plus4(pc4_a), .next_pc(nxt_a), .redirect(redirect),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_data(data_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_pc(opc_a), .out_instr(oin_a));

  fetch_unit #(.RESET_PC(RP1), .QDEPTH(QD)) dut_b (
    .clk(clk), .rst(rst), .pc_plus4(pc4_b), .next_pc(nxt_b), .redirect(redirect),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_data(data_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_pc(opc_b), .out_instr(oin_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    m_pc[0] = t;
    m_pc[1] = t;
    exp_q.delete();
  endtask

  task automatic model_step();
    int cb;
    cb = exp_q.size() + int'(mon_popped);
    mon_popped = 0;
    if (rst) begin
      m_pc[0] = RP0; m_pc[1] = RP1; m_addr[0] = '0; m_addr[1] = '0;
      m_busy = 0; m_disc = 0; m_rst_seen = 1;
      exp_q.delete();
    end else if (!m_busy) begin
      if (redirect) redirect_to(tgt);
      else if (cb < QD) begin
        m_addr[0] = m_pc[0]; m_addr[1] = m_pc[1]; m_busy = 1; m_disc = 0;
      end
    end else if (!m_disc) begin
      if (redirect) begin
        redirect_to(tgt);
        if (imem_ack) m_busy = 0; else m_disc = 1;
      end else if (imem_ack) begin
        exp_q.push_back('{a0: m_addr[0], a1: m_addr[1]});
        m_pc[0] = m_pc[0] + 32'd4;
        m_pc[1] = m_pc[1] + 32'd4;
        m_busy  = 0;
      end
    end else begin
      if (redirect) redirect_to(tgt);
      if (imem_ack) begin m_busy = 0; m_disc = 0; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    rst       = ($urandom_range(99) < p_rst);
    redirect  = ($urandom_range(99) < p_redir);
    imem_ack  = m_busy && ($urandom_range(99) < p_ack);
    out_ready = ($urandom_range(99) < p_ready);
    tgt       = ($urandom_range(3) == 0) ? 32'h100 : ($urandom() & 32'hFFFF_FFFC);
  endtask

  // Park the control model in a fresh, un-acked request (bounded wait).
  task automatic wait_req(input string name);
    int n = 0;
    while (!(m_busy && !m_disc && !imem_ack) && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) begin
      bad++;
      total++;
      $display("FAIL %s: no fetch request within 40 cycles", name);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      exp_t e;
      chk("imem_req_a", {31'd0, req_a}, {31'd0, m_busy});
      chk("imem_req_b", {31'd0, req_b}, {31'd0, m_busy});
      if (m_busy) begin
        chk("imem_addr_a", addr_a, m_addr[0]);
        chk("imem_addr_b", addr_b, m_addr[1]);
      end
      chk("pc_plus4_a", pc4_a, m_pc[0] + 32'd4);
      chk("pc_plus4_b", pc4_b, m_pc[1] + 32'd4);
      chk("out_valid_a", {31'd0, ov_a}, {31'd0, exp_q.size() != 0});
      chk("out_valid_b", {31'd0, ov_b}, {31'd0, exp_q.size() != 0});
      if (m_rst_seen) begin
        chk("rst_out_pc_a", opc_a, '0);
        chk("rst_out_instr_a", oin_a, '0);
        chk("rst_out_pc_b", opc_b, '0);
        m_rst_seen = 0;
      end
      if (ov_a && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc_a", opc_a, e.a0);
        chk("out_instr_a", oin_a, memf(e.a0));
        chk("out_pc_b", opc_b, e.a1);
        chk("out_instr_b", oin_b, memf(e.a1));
        mon_popped = 1;
      end
    end
  end

  initial begin
    m_pc[0] = RP0; m_pc[1] = RP1; m_addr[0] = '0; m_addr[1] = '0;
    cycle();
    run = 1;
    cycle();
    // Streaming with an always-ready consumer and prompt acks.
    p_rst = 0; p_ack = 100; p_redir = 0; p_ready = 100;
    repeat (20) cycle();
    // Back-pressure: queue fills, fetching stalls, then drains in order.
    p_ready = 0;
    repeat (15) cycle();
    p_ready = 100;
    repeat (10) cycle();
    // Redirect to 0x100 while a request is pending without ack.
    p_ack = 0;
    wait_req("redir_req");
    redirect = 1; tgt = 32'h100;
    p_ack = 100;
    cycle();
    repeat (8) cycle();
    // Redirect coincident with the ack.
    p_ack = 0;
    wait_req("redir_ack");
    redirect = 1; imem_ack = 1; tgt = 32'h0000_0240;
    p_ack = 100;
    cycle();
    repeat (8) cycle();
    // Reset mid-request with one entry queued.
    p_ready = 0; p_ack = 0;
    repeat (40) begin
      if (!(exp_q.size() == 1 && m_busy)) begin
        imem_ack = m_busy;
        cycle();
      end
    end
    if (!(exp_q.size() == 1 && m_busy)) begin
      bad++;
      total++;
      $display("FAIL rst_mid_req: setup not reached");
    end
    rst = 1; imem_ack = 0; redirect = 0;
    p_ready = 100; p_ack = 100;
    cycle();
    repeat (5) cycle();
    // Random mix.
    p_ack = 40; p_redir = 8; p_ready = 60; p_rst = 1;
    repeat (3000) cycle();
    p_rst = 0; p_redir = 0;
    repeat (20) cycle();
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 SHALL provide RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide QDEPTH, default 2, the output queue depth in entries; legal values are 2, 4 and 8.

Interface
REQ-003 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have pc_plus4, output, 32 bits: current PC + 4; drives the PC-select mux input1.
REQ-006 SHALL have next_pc, input, 32 bits: PC-select mux output (pc_plus4 or branch target).
REQ-007 SHALL have redirect, input, 1 bit: branch/jump taken; also drives the mux selector.
REQ-008 SHALL have imem_req, output, 1 bit: instruction memory request.
REQ-009 SHALL have imem_addr, output, 32 bits: request address.
REQ-010 SHALL have imem_ack, input, 1 bit: response valid, asserted at most once per request.
REQ-011 SHALL have imem_data, input, 32 bits: instruction word, valid with imem_ack.
REQ-012 SHALL have out_valid, output, 1 bit; out_ready, input, 1 bit; out_pc, output, 32 bits; out_instr, output, 32 bits. These form the handshake to decode.

Function
REQ-013 SHALL compute pc_plus4 = pc + 32'd4 combinationally, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-014 SHALL implement FSM states IDLE, REQ and DROP, with imem_req = (state==REQ || state==DROP).
REQ-015 In IDLE with no redirect and count + 0 < QDEPTH, the FSM SHALL latch imem_addr <= pc and go to REQ; otherwise it SHALL stay in IDLE.
REQ-016 In REQ, imem_req and imem_addr SHALL stay stable until imem_ack; an ack in the first REQ cycle is legal.
REQ-017 REQ with imem_ack and no redirect SHALL push {imem_addr, imem_data} to the queue tail, load pc <= next_pc and go to IDLE.
REQ-018 REQ with redirect and no imem_ack SHALL load pc <= next_pc, flush the queue and go to DROP.
REQ-019 REQ with redirect and imem_ack SHALL discard the response, load pc <= next_pc, flush the queue and go to IDLE.
REQ-020 DROP SHALL keep imem_req high, discard the response on imem_ack and go to IDLE.
REQ-021 Redirect in DROP SHALL load pc <= next_pc, flush the queue and stay in DROP.
REQ-022 Redirect in IDLE SHALL load pc <= next_pc, flush the queue and stay in IDLE for that cycle.
REQ-023 Outside redirect and the REQ-ack case, pc SHALL hold.
REQ-024 out_valid SHALL equal (count != 0); out_pc and out_instr SHALL present the queue head.
REQ-025 A pop SHALL occur when out_valid && out_ready; head data SHALL hold while out_valid && !out_ready.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-027 Flush SHALL set count to 0 and out_valid to 0 on the next cycle. A pop in the same cycle SHALL count as transferred. A push in the same cycle SHALL be dropped.
REQ-028 A push SHALL never find the queue full, because the slot is reserved at IDLE->REQ and pops only reduce count.
REQ-029 Fetch throughput SHALL be at most one instruction per 2 cycles, since IDLE sits between requests.

Reset
REQ-030 On rst: pc = RESET_PC, state = IDLE, count = 0, queue pointers = 0, imem_addr = 0, imem_req = 0, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-031 rst SHALL take priority over redirect, ack and pop. Reset during REQ/DROP drops imem_req on the next cycle, and a later stale imem_ack SHALL be ignored.

Verification
REQ-032 Reset, then out_ready=1 with memory acking the cycle after the request -> imem_addr sequence 0,4,8; out_pc 0,4,8 with matching out_instr.
REQ-033 out_ready=0 with QDEPTH=2 -> exactly 2 entries fetched (pc 0,4), imem_req stays 0. After out_ready=1 the pops return pc 0 then 4 and fetching resumes at 8.
REQ-034 Redirect with next_pc=32'h100 while in REQ at addr 8 and no ack -> DROP. Ack for addr 8 is discarded, queue is empty, and the next imem_addr is 32'h100.
REQ-035 Redirect and imem_ack in the same cycle -> response discarded, out_valid=0 next cycle, next request at next_pc.
REQ-036 RESET_PC=32'hFFFF_FFFC -> pc_plus4=0. The second fetch address is 32'h0000_0000.
REQ-037 Assert rst mid-REQ with 1 entry queued -> next cycle imem_req=0, out_valid=0, pc=RESET_PC.
